// File: rtl/lfsr_bcd_pkg.sv
// Shared types and helpers for the LFSR random source and its BCD converter.
package lfsr_bcd_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        CONV = 1'b1
    } state_e;

    localparam logic [7:0] DEFAULT_TAPS_W8 = 8'hB8;

    // Double-dabble correction: a nibble of 5 or more would overflow past 9 after the shift.
    function automatic logic [3:0] add3_nibble(input logic [3:0] nib);
        return (nib >= 4'd5) ? nib + 4'd3 : nib;
    endfunction

    function automatic longint unsigned pow10(input int unsigned n);
        longint unsigned r;
        r = 1;
        for (int unsigned i = 0; i < n; i++) begin
            r = r * 10;
        end
        return r;
    endfunction

endpackage

// File: rtl/lfsr_bcd_gen_if.sv
// Request/seed/result bundle between the random source and its consumer.
interface lfsr_bcd_gen_if #(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
);
    logic                  req;
    logic                  seed_ld;
    logic [WIDTH-1:0]      seed_in;
    logic [WIDTH-1:0]      rand_out;
    logic [4*DIGITS-1:0]   bcd_out;
    logic                  busy;
    logic                  valid;

    modport master (
        output req, seed_ld, seed_in,
        input  rand_out, bcd_out, busy, valid
    );

    modport slave (
        input  req, seed_ld, seed_in,
        output rand_out, bcd_out, busy, valid
    );
endinterface

// File: rtl/bin2bcd_seq.sv
// Sequential shift-and-add-3 binary to BCD converter, one bit per cycle.
module bin2bcd_seq
    import lfsr_bcd_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [WIDTH-1:0]    bin_in,
    output logic                busy,
    output logic                done,
    output logic [4*DIGITS-1:0] bcd
);

    localparam int ACC_W = 4 * DIGITS;
    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]   bin_q, bin_d;
    logic [ACC_W-1:0]   acc_adj;
    logic [ACC_W-1:0]   acc_shift;
    logic               last_shift;

    always_comb begin
        acc_adj = '0;
        for (int i = 0; i < DIGITS; i++) begin
            acc_adj[4*i +: 4] = add3_nibble(acc_q[4*i +: 4]);
        end
    end

    assign acc_shift  = (acc_adj << 1) | ACC_W'(bin_q[WIDTH-1]);
    assign last_shift = (state_q == CONV) && (count_q == CNT_W'(WIDTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            count_q <= '0;
            acc_q   <= '0;
            bin_q   <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            acc_q   <= acc_d;
            bin_q   <= bin_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = CONV;
            CONV:    if (last_shift) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        count_d = count_q;
        acc_d   = acc_q;
        bin_d   = bin_q;
        if (state_q == IDLE && start) begin
            count_d = '0;
            acc_d   = '0;
            bin_d   = bin_in;
        end else if (state_q == CONV) begin
            count_d = count_q + CNT_W'(1);
            acc_d   = acc_shift;
            bin_d   = bin_q << 1;
        end
    end

    // The finished digits are the accumulator as it leaves the final shift.
    always_comb begin
        busy = (state_q == CONV);
        done = last_shift;
        bcd  = acc_shift;
    end

endmodule

// File: rtl/lfsr_bcd_gen.sv
// Fibonacci LFSR random source whose every new value is converted to BCD digits.
module lfsr_bcd_gen
    import lfsr_bcd_pkg::*;
#(
    parameter int               WIDTH  = 8,
    parameter int               DIGITS = 3,
    parameter logic [WIDTH-1:0] TAPS   = WIDTH'(DEFAULT_TAPS_W8),
    parameter logic [WIDTH-1:0] SEED   = WIDTH'(1)
) (
    input  logic           CLOCK_50,
    input  logic           rst_n,
    lfsr_bcd_gen_if.slave  bus
);

    if (WIDTH < 3) begin : g_bad_width
        $error("lfsr_bcd_gen: WIDTH must be at least 3");
    end
    if (pow10(DIGITS) <= ((64'd1 << WIDTH) - 64'd1)) begin : g_bad_digits
        $error("lfsr_bcd_gen: DIGITS too small to hold 2^WIDTH-1");
    end
    if (SEED == '0) begin : g_bad_seed
        $error("lfsr_bcd_gen: SEED must be nonzero");
    end

    logic [WIDTH-1:0]    lfsr_q, lfsr_d;
    logic [WIDTH-1:0]    lfsr_next;
    logic [4*DIGITS-1:0] bcd_out_q, bcd_out_d;
    logic                valid_q, valid_d;
    logic                conv_start;
    logic                conv_busy;
    logic                conv_done;
    logic [4*DIGITS-1:0] conv_bcd;

    assign lfsr_next  = {lfsr_q[WIDTH-2:0], ^(lfsr_q & TAPS)};
    assign conv_start = bus.req && !bus.seed_ld && !conv_busy;

    // A zero seed would lock the register, so it is replaced by 1.
    always_comb begin
        lfsr_d = lfsr_q;
        if (!conv_busy) begin
            if (bus.seed_ld) begin
                lfsr_d = (bus.seed_in == '0) ? WIDTH'(1) : bus.seed_in;
            end else if (bus.req) begin
                lfsr_d = lfsr_next;
            end
        end
    end

    always_comb begin
        bcd_out_d = conv_done ? conv_bcd : bcd_out_q;
        valid_d   = conv_done;
    end

    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_q    <= SEED;
            bcd_out_q <= '0;
            valid_q   <= 1'b0;
        end else begin
            lfsr_q    <= lfsr_d;
            bcd_out_q <= bcd_out_d;
            valid_q   <= valid_d;
        end
    end

    bin2bcd_seq #(
        .WIDTH  (WIDTH),
        .DIGITS (DIGITS)
    ) u_bin2bcd (
        .clk    (CLOCK_50),
        .rst_n  (rst_n),
        .start  (conv_start),
        .bin_in (lfsr_next),
        .busy   (conv_busy),
        .done   (conv_done),
        .bcd    (conv_bcd)
    );

    assign bus.rand_out = lfsr_q;
    assign bus.bcd_out  = bcd_out_q;
    assign bus.busy     = conv_busy;
    assign bus.valid    = valid_q;

endmodule

// File: tb/tb_lfsr_bcd_gen.sv
// Self-checking bench: a cycle-level behavioural model compared every cycle plus directed literals.
`timescale 1ns/1ps
module tb_lfsr_bcd_gen;

    localparam int         WIDTH  = 8;
    localparam int         DIGITS = 3;
    localparam logic [7:0] TAPS   = 8'hB8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    int checks = 0;
    int errors = 0;

    lfsr_bcd_gen_if #(.WIDTH(WIDTH), .DIGITS(DIGITS)) bus ();

    lfsr_bcd_gen #(
        .WIDTH  (WIDTH),
        .DIGITS (DIGITS),
        .TAPS   (TAPS),
        .SEED   (8'h01)
    ) dut (
        .CLOCK_50 (clk),
        .rst_n    (rst_n),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    // Model state: what the outputs must show, derived from the behavioural rules.
    logic [7:0]  m_rand    = 8'h01;
    logic [7:0]  m_pending = 8'h00;
    logic [11:0] m_bcd     = 12'h000;
    logic        m_valid   = 1'b0;
    int          m_remain  = 0;

    function automatic logic [7:0] modelStep(input logic [7:0] v);
        logic fb;
        fb = ($countones(v & TAPS) % 2) == 1;
        return {v[6:0], fb};
    endfunction

    function automatic logic [11:0] toBcd(input int v);
        logic [11:0] r;
        int p;
        r = '0;
        p = 1;
        for (int d = 0; d < DIGITS; d++) begin
            r[4*d +: 4] = 4'((v / p) % 10);
            p = p * 10;
        end
        return r;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_rand   = 8'h01;
            m_bcd    = 12'h000;
            m_valid  = 1'b0;
            m_remain = 0;
        end else begin
            m_valid = 1'b0;
            if (m_remain > 0) begin
                m_remain--;
                if (m_remain == 0) begin
                    m_bcd   = toBcd(int'(m_pending));
                    m_valid = 1'b1;
                end
            end else if (bus.seed_ld) begin
                m_rand = (bus.seed_in == 8'h00) ? 8'h01 : bus.seed_in;
            end else if (bus.req) begin
                m_rand    = modelStep(m_rand);
                m_pending = m_rand;
                m_remain  = WIDTH;
            end
        end
    end

    always @(negedge clk) begin
        checkOutput("cyc_rand_out", 64'(bus.rand_out), 64'(m_rand));
        checkOutput("cyc_busy",     64'(bus.busy),     64'(m_remain > 0));
        checkOutput("cyc_valid",    64'(bus.valid),    64'(m_valid));
        checkOutput("cyc_bcd_out",  64'(bus.bcd_out),  64'(m_bcd));
    end

    task automatic applyStimulus(input logic r, input logic s, input logic [7:0] sv);
        @(posedge clk);
        #1;
        bus.req     = r;
        bus.seed_ld = s;
        bus.seed_in = sv;
    endtask

    task automatic issueReq();
        applyStimulus(1'b1, 1'b0, 8'h00);
        applyStimulus(1'b0, 1'b0, 8'h00);
    endtask

    task automatic waitValid(output int lat, output int bcyc);
        lat  = 0;
        bcyc = bus.busy ? 1 : 0;
        while (!bus.valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
            if (bus.busy) bcyc++;
        end
        if (!bus.valid) checkOutput("valid_timeout", 64'(0), 64'(1));
    endtask

    task automatic countValids(input int cycles, output int n);
        n = 0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            #1;
            if (bus.valid) n++;
        end
    endtask

    initial begin
        logic [7:0] exp_seq [4];
        logic [255:0] seen;
        logic [7:0] v;
        int lat, bcyc, nv;

        exp_seq = '{8'h02, 8'h04, 8'h08, 8'h11};
        bus.req     = 1'b0;
        bus.seed_ld = 1'b0;
        bus.seed_in = 8'h00;
        rst_n       = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_rand_out", 64'(bus.rand_out), 64'h01);
        checkOutput("rst_bcd_out",  64'(bus.bcd_out),  64'h000);
        checkOutput("rst_busy",     64'(bus.busy),     64'h0);
        checkOutput("rst_valid",    64'(bus.valid),    64'h0);
        rst_n = 1'b1;

        $display("[TB] four requests from reset");
        for (int i = 0; i < 4; i++) begin
            issueReq();
            checkOutput("seq_rand_out", 64'(bus.rand_out), 64'(exp_seq[i]));
            waitValid(lat, bcyc);
            checkOutput("seq_latency", 64'(lat), 64'd8);
            checkOutput("seq_busy_cycles", 64'(bcyc), 64'd8);
        end
        checkOutput("seq_final_bcd", 64'(bus.bcd_out), 64'h017);

        $display("[TB] request in the valid cycle");
        bus.req = 1'b1;
        @(posedge clk);
        #1;
        bus.req = 1'b0;
        checkOutput("b2b_busy", 64'(bus.busy), 64'h1);
        checkOutput("b2b_rand_out", 64'(bus.rand_out), 64'h23);
        waitValid(lat, bcyc);
        checkOutput("b2b_latency", 64'(lat), 64'd8);
        checkOutput("b2b_bcd_out", 64'(bus.bcd_out), 64'h035);

        $display("[TB] seed loads");
        applyStimulus(1'b0, 1'b1, 8'hFF);
        applyStimulus(1'b0, 1'b0, 8'h00);
        checkOutput("seed_ff_rand", 64'(bus.rand_out), 64'hFF);
        issueReq();
        checkOutput("seed_ff_step", 64'(bus.rand_out), 64'hFE);
        waitValid(lat, bcyc);
        checkOutput("seed_ff_bcd", 64'(bus.bcd_out), 64'h254);

        applyStimulus(1'b0, 1'b1, 8'h00);
        applyStimulus(1'b0, 1'b0, 8'h00);
        checkOutput("seed_zero_rand", 64'(bus.rand_out), 64'h01);

        applyStimulus(1'b1, 1'b1, 8'h5A);
        applyStimulus(1'b0, 1'b0, 8'h00);
        checkOutput("seed_req_rand", 64'(bus.rand_out), 64'h5A);
        checkOutput("seed_req_busy", 64'(bus.busy), 64'h0);
        countValids(10, nv);
        checkOutput("seed_req_no_valid", 64'(nv), 64'd0);

        $display("[TB] requests and seed loads while busy");
        applyStimulus(1'b1, 1'b0, 8'h00);
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b1, 8'h33);
        applyStimulus(1'b0, 1'b0, 8'h00);
        checkOutput("busy_frozen_rand", 64'(bus.rand_out), 64'hB4);
        countValids(15, nv);
        checkOutput("busy_one_valid", 64'(nv), 64'd1);
        checkOutput("busy_bcd_out", 64'(bus.bcd_out), 64'h180);

        $display("[TB] reset in the middle of a conversion");
        issueReq();
        checkOutput("mid_rand_before", 64'(bus.rand_out), 64'h69);
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("mid_rst_rand", 64'(bus.rand_out), 64'h01);
        checkOutput("mid_rst_bcd",  64'(bus.bcd_out),  64'h000);
        checkOutput("mid_rst_busy", 64'(bus.busy),     64'h0);
        checkOutput("mid_rst_valid", 64'(bus.valid),   64'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        countValids(12, nv);
        checkOutput("mid_rst_no_valid", 64'(nv), 64'd0);
        issueReq();
        checkOutput("post_rst_rand", 64'(bus.rand_out), 64'h02);
        waitValid(lat, bcyc);
        checkOutput("post_rst_bcd", 64'(bus.bcd_out), 64'h002);

        $display("[TB] full period from seed 1");
        applyStimulus(1'b0, 1'b1, 8'h01);
        applyStimulus(1'b0, 1'b0, 8'h00);
        seen    = '0;
        seen[1] = 1'b1;
        for (int i = 1; i <= 255; i++) begin
            issueReq();
            v = bus.rand_out;
            if (i < 255) begin
                checkOutput("period_fresh", 64'((v == 8'h00) || seen[v]), 64'd0);
                seen[v] = 1'b1;
            end else begin
                checkOutput("period_wrap", 64'(v), 64'h01);
            end
            waitValid(lat, bcyc);
            checkOutput("period_bcd", 64'(bus.bcd_out), 64'(toBcd(int'(v))));
        end

        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
